// File: rtl/alu_out_writeback_pkg.sv
// alu_out_writeback_pkg
//   Shared types for the ALU writeback path.
//   data_src_t  : operand/destination kind, shared with the operand-source path.
//   wb_state_t  : writeback FSM states (fixed 3-bit encodings).
//   wb_cnt_w()  : width of the mem_ack timeout counter for a given TIMEOUT.
package alu_out_writeback_pkg;

    typedef enum logic [1:0] {
        SRC_REG       = 2'd0,
        SRC_IMMEDIATE = 2'd1,
        SRC_MEM_ADDR  = 2'd2,
        SRC_INDIRECT  = 2'd3
    } data_src_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REG_WR = 3'd1,
        PTR_RD = 3'd2,
        MEM_WR = 3'd3,
        ERR    = 3'd4
    } wb_state_t;

    localparam int unsigned WB_TIMEOUT_DEF = 16;
    localparam int unsigned WB_CNT_W       = $clog2(WB_TIMEOUT_DEF + 1);

    // Counter must be able to hold TIMEOUT; keep at least one bit.
    function automatic int unsigned wb_cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/alu_out_writeback_if.sv
// alu_out_writeback_if
//   Bundles the upstream valid/ready request and the downstream register-file
//   and memory write ports of the writeback block.
//   slave  : the writeback block (accepts requests, drives rf/mem ports).
//   master : the surrounding environment (ALU issuing requests, memory acking).
interface alu_out_writeback_if
    import alu_out_writeback_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned REG_AW = 3
) ();

    logic              in_valid;
    logic              in_ready;
    data_src_t         dest;
    logic [WIDTH-1:0]  result;
    logic [ADDR_W-1:0] addr;
    logic [REG_AW-1:0] reg_idx;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [WIDTH-1:0]  rf_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_ack;

    logic              done;
    logic              err;

    modport slave (
        input  in_valid, dest, result, addr, reg_idx, mem_rdata, mem_ack,
        output in_ready, rf_we, rf_waddr, rf_wdata,
               mem_req, mem_we, mem_addr, mem_wdata, done, err
    );

    modport master (
        output in_valid, dest, result, addr, reg_idx, mem_rdata, mem_ack,
        input  in_ready, rf_we, rf_waddr, rf_wdata,
               mem_req, mem_we, mem_addr, mem_wdata, done, err
    );

endinterface

// File: rtl/alu_out_writeback_mem_ack_timer.sv
// alu_out_writeback_mem_ack_timer
//   Counts cycles spent waiting for mem_ack on one memory access.
//   clk, rst : clock, async active-high reset
//   clr      : restart the count (takes priority over en)
//   en       : a waiting cycle with no ack
//   expired  : this waiting cycle is the TIMEOUT-th without ack
module alu_out_writeback_mem_ack_timer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Flags the cycle whose increment would bring the count to TIMEOUT, so the
    // FSM leaves on that same edge; an ack in that cycle is checked first.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/alu_out_writeback.sv
// alu_out_writeback
//   Routes an ALU result to its destination: register file, memory at a direct
//   address, or memory at a pointer fetched from memory. SRC_IMMEDIATE is not a
//   writable destination and is reported through err.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   wb  : request (in_valid/in_ready, dest, result, addr, reg_idx),
//         rf write port, memory req/ack port, done/err pulses
module alu_out_writeback
    import alu_out_writeback_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_out_writeback_if.slave  wb
);

    wb_state_t         state;
    logic [WIDTH-1:0]  res_q;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [WIDTH-1:0]  rf_wdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WIDTH-1:0]  mem_wdata_q;
    logic              done_q;
    logic              err_q;

    logic [ADDR_W-1:0] ptr;
    logic              in_mem;
    logic              tmr_clr;
    logic              tmr_en;
    logic              expired;

    // Pointer read back from memory, resized to the address width.
    generate
        if (WIDTH >= ADDR_W) begin : g_ptr_trunc
            assign ptr = wb.mem_rdata[ADDR_W-1:0];
        end else begin : g_ptr_zext
            assign ptr = {{(ADDR_W - WIDTH){1'b0}}, wb.mem_rdata};
        end
    endgenerate

    assign in_mem  = (state == PTR_RD) || (state == MEM_WR);
    // Restart on entry to either memory state, including the PTR_RD->MEM_WR hop.
    assign tmr_clr = !in_mem || ((state == PTR_RD) && wb.mem_ack);
    assign tmr_en  = in_mem && !wb.mem_ack;

    generate
        if (TIMEOUT > 0) begin : g_tmr
            alu_out_writeback_mem_ack_timer #(
                .TIMEOUT (TIMEOUT),
                .CNT_W   (wb_cnt_w(TIMEOUT))
            ) u_tmr (
                .clk     (clk),
                .rst     (rst),
                .clr     (tmr_clr),
                .en      (tmr_en),
                .expired (expired)
            );
        end else begin : g_no_tmr
            assign expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            res_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rf_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb.in_valid) begin
                        res_q <= wb.result;
                        case (wb.dest)
                            SRC_REG: begin
                                state      <= REG_WR;
                                rf_we_q    <= 1'b1;
                                rf_waddr_q <= wb.reg_idx;
                                rf_wdata_q <= wb.result;
                            end
                            SRC_MEM_ADDR: begin
                                state       <= MEM_WR;
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= wb.addr;
                                mem_wdata_q <= wb.result;
                            end
                            SRC_INDIRECT: begin
                                state      <= PTR_RD;
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= wb.addr;
                            end
                            default: state <= ERR;
                        endcase
                    end
                end
                REG_WR: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                PTR_RD: begin
                    if (wb.mem_ack) begin
                        // Turn straight into the write; mem_req stays high.
                        state       <= MEM_WR;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr;
                        mem_wdata_q <= res_q;
                    end else if (expired) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                MEM_WR: begin
                    if (wb.mem_ack) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (expired) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb.in_ready  = (state == IDLE);
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_waddr  = rf_waddr_q;
    assign wb.rf_wdata  = rf_wdata_q;
    assign wb.mem_req   = mem_req_q;
    assign wb.mem_we    = mem_we_q;
    assign wb.mem_addr  = mem_addr_q;
    assign wb.mem_wdata = mem_wdata_q;
    assign wb.done      = done_q;
    assign wb.err       = err_q;

endmodule
